// File: rtl/sudoku_pkg.sv
// Shared types and constants for the sudoku job controller.
package sudoku_pkg;

   localparam int CELLS  = 81;
   localparam int CELL_W = 9;
   localparam int GRID_W = CELLS * CELL_W;

   localparam logic [6:0] LAST_IDX = 7'(CELLS - 1);

   typedef enum logic [1:0] {
      S_LOAD,
      S_START,
      S_RUN,
      S_DRAIN
   } state_t;

   localparam logic [1:0] ST_SOLVED  = 2'd0;
   localparam logic [1:0] ST_ERROR   = 2'd1;
   localparam logic [1:0] ST_TIMEOUT = 2'd2;

endpackage

// File: rtl/sudoku_job_ctrl_if.sv
// Cell-serial puzzle/result streams between a host and the job controller.
interface sudoku_job_ctrl_if;

   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_cell;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_cell;
   logic       out_last;
   logic [1:0] out_status;

   modport master (
      output in_valid, in_cell, out_ready,
      input  in_ready, out_valid, out_cell, out_last, out_status
   );

   modport slave (
      input  in_valid, in_cell, out_ready,
      output in_ready, out_valid, out_cell, out_last, out_status
   );

endinterface

// File: rtl/sudoku_cell_conv.sv
// Combinational decimal <-> one-hot cell conversion; anything not exactly one-hot decodes to 0.
module sudoku_cell_conv
   import sudoku_pkg::*;
(
   input  logic [3:0]        dec,
   output logic [CELL_W-1:0] hot,
   output logic              bad,
   input  logic [CELL_W-1:0] res_hot,
   output logic [3:0]        res_dec
);

   always_comb begin
      bad = (dec > 4'd9);
      if (dec == 4'd0 || bad)
         hot = '1;
      else
         hot = 9'd1 << (dec - 4'd1);

      res_dec = 4'd0;
      for (int i = 0; i < CELL_W; i++)
         if (res_hot == (9'd1 << i))
            res_dec = 4'(i + 1);
   end

endmodule

// File: rtl/sudoku_job_ctrl.sv
// Loads 81 serial cells, runs the solver with a cycle limit, streams 81 result cells back.
// Outputs registered (in_ready/busy decode state); result beats hold while out_ready is low.
module sudoku_job_ctrl
   import sudoku_pkg::*;
#(
   parameter logic [31:0] MAX_CYCLES = 32'd1_000_000
) (
   input  logic              clk,
   input  logic              rst,
   sudoku_job_ctrl_if.slave  bus,
   output logic [31:0]       cycle_count,
   output logic              bad_input,
   output logic              busy,
   output logic              slv_start,
   output logic              slv_clr,
   output logic [GRID_W-1:0] slv_inGrid,
   input  logic [GRID_W-1:0] slv_outGrid,
   input  logic              slv_done,
   input  logic              slv_error
);

   state_t            state, state_nxt;
   logic [6:0]        idx;
   logic [6:0]        rd_idx;
   logic [9:0]        wr_base, rd_base;
   logic [GRID_W-1:0] result;
   logic              in_fire, out_fire, run_end;
   logic [1:0]        run_status;
   logic [CELL_W-1:0] wr_hot, rd_hot;
   logic              wr_bad;
   logic [3:0]        rd_dec;

   assign bus.in_ready = (state == S_LOAD);
   assign busy         = (state != S_LOAD);
   assign in_fire      = bus.in_ready && bus.in_valid;
   assign out_fire     = (state == S_DRAIN) && bus.out_valid && bus.out_ready;

   // Output cell is registered, so decode the cell about to be presented:
   // cell 0 straight off the solver on capture, otherwise the next result cell.
   assign rd_idx  = (idx == LAST_IDX) ? 7'd0 : idx + 7'd1;
   assign rd_base = 10'(rd_idx) * 10'd9;
   assign wr_base = 10'(GRID_W - 1) - 10'(idx) * 10'd9;
   assign rd_hot  = (state == S_DRAIN) ? result[rd_base +: CELL_W] : slv_outGrid[CELL_W-1:0];

   sudoku_cell_conv u_conv (
      .dec     (bus.in_cell),
      .hot     (wr_hot),
      .bad     (wr_bad),
      .res_hot (rd_hot),
      .res_dec (rd_dec)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_LOAD;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      run_end    = 1'b0;
      run_status = ST_SOLVED;
      case (state)
         S_LOAD:  if (in_fire && idx == LAST_IDX) state_nxt = S_START;
         S_START: state_nxt = S_RUN;
         S_RUN: begin
            run_end = 1'b1;
            if (slv_error)
               run_status = ST_ERROR;
            else if (slv_done)
               run_status = ST_SOLVED;
            else if (cycle_count == MAX_CYCLES - 32'd1)
               run_status = ST_TIMEOUT;
            else
               run_end = 1'b0;
            if (run_end) state_nxt = S_DRAIN;
         end
         S_DRAIN: if (out_fire && idx == LAST_IDX) state_nxt = S_LOAD;
         default: state_nxt = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx            <= '0;
         result         <= '0;
         cycle_count    <= '0;
         bad_input      <= 1'b0;
         slv_start      <= 1'b0;
         slv_clr        <= 1'b0;
         slv_inGrid     <= '0;
         bus.out_valid  <= 1'b0;
         bus.out_cell   <= '0;
         bus.out_last   <= 1'b0;
         bus.out_status <= '0;
      end else begin
         slv_start <= 1'b0;
         slv_clr   <= 1'b0;
         case (state)
            S_LOAD: if (in_fire) begin
               slv_inGrid[wr_base -: CELL_W] <= wr_hot;
               bad_input <= (idx == 7'd0) ? wr_bad : (bad_input | wr_bad);
               if (idx == LAST_IDX) begin
                  idx       <= '0;
                  slv_start <= 1'b1;
               end else begin
                  idx <= idx + 7'd1;
               end
            end
            S_START: cycle_count <= '0;
            S_RUN: begin
               if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
               if (run_end) begin
                  result         <= slv_outGrid;
                  slv_clr        <= (run_status == ST_TIMEOUT);
                  bus.out_valid  <= 1'b1;
                  bus.out_cell   <= rd_dec;
                  bus.out_last   <= 1'b0;
                  bus.out_status <= run_status;
               end
            end
            S_DRAIN: if (out_fire) begin
               if (idx == LAST_IDX) begin
                  idx           <= '0;
                  bus.out_valid <= 1'b0;
                  bus.out_last  <= 1'b0;
               end else begin
                  idx          <= idx + 7'd1;
                  bus.out_cell <= rd_dec;
                  bus.out_last <= (idx == LAST_IDX - 7'd1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sudoku_job_ctrl.sv
// Self-checking bench for sudoku_job_ctrl: table-driven jobs, randomized jobs against a
// cycle-level outcome model, and reset-during-RUN / reset-during-DRAIN sequences.
module tb_sudoku_job_ctrl;
   import sudoku_pkg::*;

   localparam int MAXC = 600;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  cycle_count;
   logic         bad_input, busy, slv_start, slv_clr;
   logic [728:0] slv_inGrid;
   logic [728:0] slv_outGrid;
   logic         slv_done, slv_error;

   sudoku_job_ctrl_if bus ();

   sudoku_job_ctrl #(.MAX_CYCLES(32'(MAXC))) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .cycle_count (cycle_count),
      .bad_input   (bad_input),
      .busy        (busy),
      .slv_start   (slv_start),
      .slv_clr     (slv_clr),
      .slv_inGrid  (slv_inGrid),
      .slv_outGrid (slv_outGrid),
      .slv_done    (slv_done),
      .slv_error   (slv_error)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int cyc = 0, run_ctr = 0, done_at = 0, err_at = 0;
   int start_cyc = 0, ov_cyc = 0, n_clr = 0, last_hs = 0;
   logic ov_prev = 1'b0;

   logic [3:0] cells   [81];
   logic [8:0] res_hot [81];
   logic [3:0] exp_out [81];

   // Solver stand-in: RUN cycle k after the start pulse sees run_ctr == k.
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk or posedge rst)
      if (rst) run_ctr <= 0;
      else if (slv_start) run_ctr <= 1;
      else if (busy && run_ctr != 0) run_ctr <= run_ctr + 1;
      else run_ctr <= 0;
   assign slv_done  = (done_at != 0) && (run_ctr == done_at);
   assign slv_error = (err_at != 0) && (run_ctr == err_at);

   always @(negedge clk) begin
      if (slv_start) start_cyc <= cyc;
      if (slv_clr) n_clr <= n_clr + 1;
      if (bus.out_valid && !ov_prev) ov_cyc <= cyc;
      ov_prev <= bus.out_valid;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_grid(input string name, input logic [728:0] act, input logic [728:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [8:0] enc(input logic [3:0] v);
      return (v >= 4'd1 && v <= 4'd9) ? (9'd1 << (v - 4'd1)) : 9'h1FF;
   endfunction

   function automatic logic [3:0] dec(input logic [8:0] h);
      for (int d = 1; d <= 9; d++)
         if (h == (9'd1 << (d - 1))) return 4'(d);
      return 4'd0;
   endfunction

   function automatic logic [728:0] pack_in();
      logic [728:0] g = '0;
      for (int k = 0; k < 81; k++) g[728 - 9*k -: 9] = enc(cells[k]);
      return g;
   endfunction

   // Outcome model: walk RUN cycles 1..MAXC applying error > done > timeout.
   task automatic model(input int d_at, input int e_at, output logic [1:0] st, output int cnt);
      st = ST_TIMEOUT;
      cnt = MAXC;
      for (int k = 1; k <= MAXC; k++) begin
         if (e_at == k) begin st = ST_ERROR; cnt = k; break; end
         if (d_at == k) begin st = ST_SOLVED; cnt = k; break; end
      end
   endtask

   task automatic prep();
      for (int k = 0; k < 81; k++) begin
         cells[k]   = ($urandom_range(0, 99) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         res_hot[k] = ($urandom_range(0, 9) == 0) ? 9'($urandom) : (9'd1 << $urandom_range(0, 8));
      end
   endtask

   task automatic fill_exp();
      for (int k = 0; k < 81; k++) exp_out[k] = dec(res_hot[k]);
   endtask

   task automatic chk_reset(input string name);
      chk({name, "_ctrl"},
          {bus.in_ready, bus.out_valid, bus.out_last, bus.out_cell, bus.out_status,
           bad_input, busy, slv_start, slv_clr},
          13'b1_0_0_0000_00_0_0_0_0);
      chk({name, "_count"}, cycle_count, 0);
      chk_grid({name, "_grid"}, slv_inGrid, '0);
   endtask

   task automatic load_job();
      for (int k = 0; k < 81; k++) begin
         int w = 0;
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_cell  = cells[k];
         while (!bus.in_ready && w < 100) begin @(negedge clk); w++; end
         if (w >= 100) chk("in_ready_wait", 0, 1);
         last_hs = cyc;
         @(posedge clk);
         #1;
         if (k == 0) chk("bad_first_beat", bad_input, cells[0] > 4'd9);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out();
      int w = 0;
      while (!bus.out_valid && w < MAXC + 20) begin
         @(negedge clk);
         bus.in_valid = 1'($urandom);
         bus.in_cell  = 4'($urandom);
         w++;
      end
      bus.in_valid = 1'b0;
      chk("out_valid_wait", bus.out_valid, 1);
   endtask

   task automatic drain(input int stop_at, input logic bp, input logic [1:0] st);
      int b = 0, w = 0;
      for (int k = 0; k < 81; k++) slv_outGrid[9*k +: 9] = 9'($urandom);
      while (b < stop_at && w < 2000) begin
         chk("beat", {bus.out_valid, bus.in_ready, bus.out_cell, bus.out_last, bus.out_status},
             {1'b1, 1'b0, exp_out[b], (b == 80), st});
         bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.in_cell   = 4'($urandom);
         @(posedge clk);
         if (bus.out_ready) b++;
         @(negedge clk);
         w++;
      end
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      if (stop_at == 81) begin
         chk("post_drain", {bus.out_valid, bus.in_ready, busy}, 3'b010);
         if (!bp) chk("b2b_cycles", w, 81);
      end
   endtask

   task automatic set_res();
      for (int k = 0; k < 81; k++) slv_outGrid[9*k +: 9] = res_hot[k];
   endtask

   task automatic run_job(input logic bp, input logic [1:0] st, input int cnt);
      int clr0;
      logic anybad = 1'b0;
      set_res();
      clr0 = n_clr;
      load_job();
      chk("start_pulse", {slv_start, busy}, 2'b11);
      chk_grid("in_grid", slv_inGrid, pack_in());
      for (int k = 0; k < 81; k++) anybad |= (cells[k] > 4'd9);
      chk("bad_input", bad_input, anybad);
      wait_out();
      #1;
      chk("start_cyc", start_cyc, last_hs + 1);
      chk("latency", ov_cyc - start_cyc, cnt + 1);
      chk("cycle_count", cycle_count, cnt);
      chk("clr_pulses", n_clr - clr0, st == ST_TIMEOUT);
      drain(81, bp, st);
      chk_grid("in_grid_hold", slv_inGrid, pack_in());
   endtask

   typedef struct {
      logic [3:0] c0, c7;
      int         d_at, e_at;
      logic [8:0] res0;
      logic [1:0] st;
      int         cnt;
      logic [8:0] in0, in7;
      logic       bad;
      logic [3:0] out0;
   } vec_t;

   vec_t tbl [7];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{4'd5,  4'd3,  500, 0,   9'h010, ST_SOLVED,  500, 9'h010, 9'h004, 1'b0, 4'd5};
      tbl[1] = '{4'd0,  4'd12, 1,   0,   9'h003, ST_SOLVED,  1,   9'h1FF, 9'h1FF, 1'b1, 4'd0};
      tbl[2] = '{4'd9,  4'd0,  20,  20,  9'h100, ST_ERROR,   20,  9'h100, 9'h1FF, 1'b0, 4'd9};
      tbl[3] = '{4'd1,  4'd15, 0,   0,   9'h000, ST_TIMEOUT, 600, 9'h001, 9'h1FF, 1'b1, 4'd0};
      tbl[4] = '{4'd2,  4'd4,  600, 0,   9'h1FF, ST_SOLVED,  600, 9'h002, 9'h008, 1'b0, 4'd0};
      tbl[5] = '{4'd10, 4'd9,  3,   7,   9'h080, ST_SOLVED,  3,   9'h1FF, 9'h100, 1'b1, 4'd8};
      tbl[6] = '{4'd7,  4'd1,  0,   599, 9'h040, ST_ERROR,   599, 9'h040, 9'h001, 1'b0, 4'd7};

      bus.in_valid  = 1'b0;
      bus.in_cell   = '0;
      bus.out_ready = 1'b0;
      slv_outGrid   = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_reset("rst_init");
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         prep();
         for (int k = 0; k < 81; k++) if (cells[k] > 4'd9) cells[k] = 4'd0;
         cells[0]   = tbl[i].c0;
         cells[7]   = tbl[i].c7;
         res_hot[0] = tbl[i].res0;
         fill_exp();
         exp_out[0] = tbl[i].out0;
         done_at    = tbl[i].d_at;
         err_at     = tbl[i].e_at;
         run_job(1'b0, tbl[i].st, tbl[i].cnt);
         chk("tbl_cell0", slv_inGrid[728 -: 9], tbl[i].in0);
         chk("tbl_cell7", slv_inGrid[665 -: 9], tbl[i].in7);
         chk("tbl_bad", bad_input, tbl[i].bad);
      end

      for (int i = 0; i < 10; i++) begin
         logic [1:0] st;
         int cnt;
         prep();
         fill_exp();
         done_at = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 700);
         err_at  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 700) : 0;
         model(done_at, err_at, st, cnt);
         run_job(1'b1, st, cnt);
      end

      // Reset while the solver is running.
      prep();
      cells[0] = 4'd11;
      done_at = 0;
      err_at  = 0;
      set_res();
      load_job();
      repeat (50) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk_reset("rst_run");
      @(negedge clk);
      rst = 1'b0;

      // Reset in the middle of draining a result.
      prep();
      fill_exp();
      done_at = 0;
      err_at  = 30;
      set_res();
      load_job();
      wait_out();
      #1;
      drain(40, 1'b0, ST_ERROR);
      #2 rst = 1'b1;
      #1 chk_reset("rst_drain");
      @(negedge clk);
      rst = 1'b0;

      prep();
      fill_exp();
      done_at = 50;
      err_at  = 0;
      run_job(1'b1, ST_SOLVED, 50);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sudoku_job_ctrl.md
# sudoku_job_ctrl

Job controller for the `sudoku_search` solver core. It accepts a puzzle as 81 serial decimal cells over a valid/ready stream and packs them into the solver's one-hot grid. It then pulses the solver start, counts solve cycles, and enforces a cycle timeout. The captured result is streamed back as 81 decimal cells with a status code, so the solver can sit behind a narrow host or streaming interface instead of a 729-bit bus.

## Interface
- `MAX_CYCLES`, default 32'd1_000_000: solve-cycle limit before timeout (1..2^32-1).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  input cell valid.
- `in_ready`  out  1  controller accepts a cell.
- `in_cell`  in  4  decimal cell: 0 = blank, 1..9 = given.
- `out_valid`  out  1  output cell valid.
- `out_ready`  in  1  sink accepts a cell.
- `out_cell`  out  4  decimal result: 1..9, or 0 if the solver cell is not one-hot.
- `out_last`  out  1  marks cell 80.
- `out_status`  out  2  0 = SOLVED, 1 = ERROR, 2 = TIMEOUT; valid while `out_valid`.
- `cycle_count`  out  32  solve cycles of the current or last job.
- `bad_input`  out  1  sticky per job: some `in_cell` > 9 was accepted.
- `busy`  out  1  state is not LOAD.
- `slv_start`  out  1  one-cycle solver start pulse.
- `slv_clr`  out  1  one-cycle solver abort on timeout.
- `slv_inGrid`  out  729  packed puzzle. Cell k occupies [728-9k -: 9].
- `slv_outGrid`  in  729  solver result. Cell k occupies [9k+8 : 9k].
- `slv_done`, `slv_error`  in  1  solver completion flags.

## Operation
- States: LOAD, START, RUN, DRAIN.
- LOAD:
  - `in_ready`=1; each handshake writes cell `idx` (0..80), then `idx`++.
  - Cell encoding: 0 → 9'h1FF; d = 1..9 → 1<<(d-1); values >9 → 9'h1FF and set `bad_input`.
  - The handshake at `idx`=80 → START, `idx`←0.
- START:
  - `slv_start`=1 for exactly one cycle; `cycle_count`←0.
  - `bad_input` cleared at the first beat of the next job, not here.
  - → RUN.
- RUN:
  - `cycle_count`++ each cycle, saturating at 2^32-1.
  - `slv_error`=1 → status ERROR.
  - Else `slv_done`=1 → SOLVED.
  - Else `cycle_count`==`MAX_CYCLES`-1 → TIMEOUT, with `slv_clr`=1 that same cycle.
  - On any of these: capture `slv_outGrid` into a result register → DRAIN.
- DRAIN:
  - `out_valid`=1; `out_cell` = decimal of result cell `idx`.
  - Each handshake advances `idx`; `out_last`=(`idx`==80).
  - Final handshake → LOAD, `idx`←0.
- Priority: error > done > timeout. Done on the timeout cycle counts as SOLVED.
- `in_valid` outside LOAD is ignored. `out_ready` outside DRAIN is ignored.
- `slv_inGrid` holds its value from LOAD through DRAIN. It is overwritten cell by cell during the next LOAD.

## Timing
- Reset values:
  - state LOAD, `idx`=0, `in_ready`=1.
  - `out_valid`=0, `out_last`=0, `out_cell`=0, `out_status`=0.
  - `cycle_count`=0, `bad_input`=0, `busy`=0.
  - `slv_start`=0, `slv_clr`=0, `slv_inGrid`=0.
- Reset mid-job (any state): immediate return to reset values; a partially drained result is lost.
- Last input handshake at cycle T:
  - `slv_start` high in T+1.
  - RUN from T+2.
- Done sampled at cycle D: `out_valid` rises at D+1.
- `cycle_count` = RUN cycles up to and including the terminating cycle (done in the first RUN cycle → 1).
- Timeout: `out_valid` rises exactly `MAX_CYCLES`+1 cycles after `slv_start`.
- Output stream:
  - `out_*` registered and stable while `out_valid`·!`out_ready`.
  - Back-to-back beats when `out_ready` is held high: 81 cycles.
- `in_ready` rises the cycle after the final output handshake.
- All outputs registered except `in_ready`/`busy`, which decode directly from state.

## Structure
- Package `sudoku_pkg`:
  - state enum.
  - `CELLS`=81, `CELL_W`=9, `GRID_W`=729.
  - status codes `ST_SOLVED`/`ST_ERROR`/`ST_TIMEOUT`.
- Sub-module `sudoku_cell_conv`: combinational decimal↔one-hot pair, with a not-one-hot → 0 rule. Instantiated once per direction on the indexed cell. No 81-way replication.

## Test plan
- Known puzzle with a solver model that asserts done after 500 cycles:
  - `slv_inGrid` cell 0 matches the input (e.g. 5 → 9'h010; blank → 9'h1FF).
  - 81 output beats, `out_last` only on beat 80.
  - `out_status`=0, `cycle_count`=500.
- Model asserts `slv_error` and `slv_done` in the same cycle → `out_status`=1.
- `MAX_CYCLES`=100, model never done:
  - `slv_clr` pulses once.
  - `out_status`=2, `cycle_count`=100.
  - `out_valid` rises 101 cycles after `slv_start`.
- `in_cell`=12 at cell 7:
  - `bad_input`=1; cell 7 = 9'h1FF.
  - `bad_input` clears on the next job's first beat.
- Random `out_ready` backpressure: `out_cell`/`out_last` stable while stalled; exactly 81 accepted beats; `in_valid` during DRAIN not accepted.
- `rst` asserted during RUN and again at DRAIN beat 40: all outputs return to reset values immediately; the next full job completes normally.
